// File: rtl/lap_reader.sv
// Walks stored stopwatch laps on next/previous/latest commands and reads them back from the lap BRAM.
// Latency: event cycle to valid pulse is 3 cycles. Commands arriving while a read is in flight are dropped.
module lap_reader #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        comanda,
  input  logic [ADDR_W:0]   cnt,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_adr,
  output logic [WIDTH-1:0]  lap_data,
  output logic              valid,
  output logic              busy,
  output logic              empty,
  output logic [ADDR_W-1:0] ptr
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [1:0] CMD_NEXT   = 2'b01;
  localparam logic [1:0] CMD_PREV   = 2'b10;
  localparam logic [1:0] CMD_LATEST = 2'b11;

  state_t            state;
  logic [1:0]        cmd_q;
  logic              cmd_evt;
  logic [ADDR_W:0]   cnt_m1;
  logic [ADDR_W-1:0] ptr_nxt;

  assign empty   = (cnt == '0);
  // cnt == 2**ADDR_W yields cnt_m1 = 2**ADDR_W-1, which fits after truncation
  assign cnt_m1  = cnt - 1'b1;
  assign cmd_evt = (state == IDLE) && en && (comanda != 2'b00) &&
                   (comanda != cmd_q) && !empty;

  always_comb begin
    ptr_nxt = ptr;
    case (comanda)
      CMD_NEXT:   ptr_nxt = ({1'b0, ptr} >= cnt_m1) ? '0 : ptr + 1'b1;
      CMD_PREV:   ptr_nxt = ((ptr == '0) || ({1'b0, ptr} >= cnt)) ?
                            cnt_m1[ADDR_W-1:0] : ptr - 1'b1;
      CMD_LATEST: ptr_nxt = cnt_m1[ADDR_W-1:0];
      default:    ptr_nxt = ptr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cmd_q    <= 2'b00;
      ptr      <= '0;
      rd_en    <= 1'b0;
      rd_adr   <= '0;
      lap_data <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cmd_q <= comanda;
      valid <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_evt) begin
            ptr    <= ptr_nxt;
            rd_adr <= ptr_nxt;
            rd_en  <= 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // BRAM data for the ISSUE strobe is present during this cycle
          lap_data <= rd_data;
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lap_reader.sv
module tb_lap_reader;
  localparam int WIDTH  = 9;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [1:0]        comanda;
  logic [ADDR_W:0]   cnt;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_adr;
  logic [WIDTH-1:0]  lap_data;
  logic              valid;
  logic              busy;
  logic              empty;
  logic [ADDR_W-1:0] ptr;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mem [DEPTH];
  int exp_ptr = 0;
  int exp_lap = 0;

  always #5 clk = ~clk;

  // lap BRAM: synchronous read, data available the cycle after rd_en
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_adr];

  lap_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .comanda(comanda), .cnt(cnt),
    .rd_data(rd_data), .rd_en(rd_en), .rd_adr(rd_adr), .lap_data(lap_data),
    .valid(valid), .busy(busy), .empty(empty), .ptr(ptr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Reference pointer movement, in plain integer arithmetic.
  function automatic int model_ptr(input int cmd, input int p, input int n);
    int last;
    last = (n - 1) % DEPTH;
    case (cmd)
      1: return (p >= n - 1) ? 0 : p + 1;
      2: return (p == 0 || p >= n) ? last : p - 1;
      3: return last;
      default: return p;
    endcase
  endfunction

  // Issue one command from a quiet idle state and check the whole read sequence.
  task automatic do_cmd(input int cmd, input bit drop_en, input string tag);
    bit fire;
    fire = en && (cmd != 0) && (cnt != 0);
    if (fire) begin
      exp_ptr = model_ptr(cmd, exp_ptr, int'(cnt));
      exp_lap = int'(mem[exp_ptr]);
    end
    comanda = 2'(cmd);
    step();
    chk({tag, "_rd_en_e1"}, int'(rd_en), int'(fire));
    chk({tag, "_ptr_e1"}, int'(ptr), exp_ptr);
    if (fire) chk({tag, "_rd_adr_e1"}, int'(rd_adr), exp_ptr);
    if (drop_en) en = 1'b0;
    step();
    chk({tag, "_busy_e2"}, int'(busy), int'(fire));
    chk({tag, "_rd_en_e2"}, int'(rd_en), 0);
    step();
    chk({tag, "_valid_e3"}, int'(valid), int'(fire));
    chk({tag, "_busy_e3"}, int'(busy), 0);
    chk({tag, "_lap_e3"}, int'(lap_data), exp_lap);
    chk({tag, "_empty"}, int'(empty), int'(cnt == 0));
    comanda = 2'b00;
    en = 1'b1;
    step();
    chk({tag, "_valid_off"}, int'(valid), 0);
  endtask

  task automatic test_reset();
    int n_rd, n_vld;
    rst = 1'b0; en = 1'b1; comanda = 2'b00; cnt = '0;
    #12;
    chk("rst_ptr", int'(ptr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_lap", int'(lap_data), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_adr", int'(rd_adr), 0);
    chk("rst_empty", int'(empty), 1);
    rst = 1'b1;
    step();
    comanda = 2'b01;
    n_rd = 0; n_vld = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_rd += int'(rd_en);
      n_vld += int'(valid);
    end
    chk("empty_no_rd", n_rd, 0);
    chk("empty_no_valid", n_vld, 0);
    chk("empty_ptr", int'(ptr), 0);
    comanda = 2'b00;
    step();
  endtask

  task automatic test_basic();
    cnt = 3;
    do_cmd(1, 0, "next1");
    chk("next1_lap_val", int'(lap_data), 'h10A);
    chk("next1_ptr_val", int'(ptr), 1);
  endtask

  task automatic test_wrap();
    do_cmd(1, 0, "to2");
    do_cmd(1, 0, "wrap_next");
    chk("wrap_next_lap", int'(lap_data), 'h005);
    do_cmd(2, 0, "wrap_prev");
    chk("wrap_prev_ptr", int'(ptr), 2);
    chk("wrap_prev_lap", int'(lap_data), 'h03B);
    do_cmd(3, 0, "latest3");
    chk("latest3_ptr", int'(ptr), 2);
  endtask

  task automatic test_hold_and_drop();
    int n_rd, n_vld;
    comanda = 2'b01;
    exp_ptr = model_ptr(1, exp_ptr, int'(cnt));
    n_rd = 0; n_vld = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_rd += int'(rd_en);
      n_vld += int'(valid);
    end
    chk("hold_rd_count", n_rd, 1);
    chk("hold_valid_count", n_vld, 1);
    chk("hold_ptr", int'(ptr), exp_ptr);
    comanda = 2'b00;
    step();
    comanda = 2'b01;
    exp_ptr = model_ptr(1, exp_ptr, int'(cnt));
    step();
    n_rd = int'(rd_en);
    comanda = 2'b10;
    for (int i = 0; i < 7; i++) begin
      step();
      n_rd += int'(rd_en);
    end
    chk("drop_rd_count", n_rd, 1);
    chk("drop_ptr", int'(ptr), exp_ptr);
    exp_lap = int'(mem[exp_ptr]);
    chk("drop_lap", int'(lap_data), exp_lap);
    comanda = 2'b00;
    step();
  endtask

  task automatic test_full_depth();
    cnt = 11'(DEPTH);
    do_cmd(3, 0, "full_latest");
    chk("full_rd_adr", int'(rd_adr), DEPTH - 1);
    do_cmd(1, 0, "full_next_wrap");
    chk("full_next_ptr", int'(ptr), 0);
    cnt = 6;
    do_cmd(3, 0, "six_latest");
    cnt = 2;
    step();
    chk("shrink_ptr_kept", int'(ptr), 5);
    do_cmd(1, 0, "shrink_next");
    chk("shrink_next_ptr", int'(ptr), 0);
  endtask

  task automatic test_reset_mid();
    cnt = 3;
    comanda = 2'b01;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_valid", int'(valid), 0);
    chk("mid_lap", int'(lap_data), 0);
    chk("mid_ptr", int'(ptr), 0);
    comanda = 2'b00;
    step();
    chk("mid_no_valid", int'(valid), 0);
    rst = 1'b1;
    exp_ptr = 0; exp_lap = 0;
    step();
    do_cmd(1, 0, "post_rst_next");
  endtask

  task automatic test_random();
    int pick;
    for (int i = 0; i < 150; i++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0)      cnt = '0;
      else if (pick == 1) cnt = 11'(DEPTH);
      else if (pick < 5)  cnt = 11'($urandom_range(1, 8));
      else if (pick < 7)  cnt = 11'($urandom_range(1, DEPTH));
      en = ($urandom_range(0, 7) != 0);
      do_cmd($urandom_range(0, 3), $urandom_range(0, 3) == 0, "rand");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
    mem[0] = 9'h005; mem[1] = 9'h10A; mem[2] = 9'h03B;
    test_reset();
    test_basic();
    test_wrap();
    test_hold_and_drop();
    test_full_depth();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
